bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single CPU-side memory/IO bus between two masters: the cpu and a DMA engine.
- The bus is address[14:0], data[15:0] and the active-low strobes rd_n, wr_n, csh_n, csl_n, select_dev.
- Sits between the masters and memory/virtual_io and owns the bus mux.
- Grants one owner at a time, round-robin, with a mandatory idle turnaround cycle between owners.
- A hold limit stops the DMA from starving the cpu.

Parameters:
- DMA_MAX_HOLD, 16, max consecutive cycles the DMA may own the bus while cpu_req is pending (range 1..255).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  cpu requests bus; held high for the whole transfer sequence
- cpu_gnt  out  1  cpu owns bus
- cpu_addr  in  15  cpu address
- cpu_data_out  in  16  cpu write data
- cpu_data_oe  in  1  cpu drives write data
- cpu_strb_n  in  5  cpu strobes, order {rd_n, wr_n, csh_n, csl_n, select_dev}
- dma_req  in  1  DMA requests bus
- dma_gnt  out  1  DMA owns bus
- dma_addr  in  15  DMA address
- dma_data_out  in  16  DMA write data
- dma_data_oe  in  1  DMA drives write data
- dma_strb_n  in  5  DMA strobes, same order as cpu_strb_n
- dma_preempt  out  1  one-cycle pulse: DMA grant revoked by hold limit
- bus_addr  out  15  to memory/io
- bus_data_out  out  16  to bus tristate driver
- bus_data_oe  out  1  enables bus_data_out onto data
- bus_strb_n  out  5  to memory/io, same order as cpu_strb_n
- owner  out  2  0 none, 1 cpu, 2 DMA (3 never driven)

Behaviour:
- Clock and reset: one clock, `clock`. Reset (`reset`) is synchronous and active-high.
- Reset values:
  - state IDLE; cpu_gnt=0, dma_gnt=0, dma_preempt=0, owner=0.
  - bus_strb_n=5'b11111, bus_addr=0, bus_data_out=0, bus_data_oe=0.
  - last_owner=DMA, so the cpu wins the first tie.
  - hold counter=0.
- Reset has priority over all events. Asserting it mid-transfer forces all outputs to reset values at that edge.
- State machine: IDLE, GNT_CPU, GNT_DMA, TURN. Grants are registered: cpu_gnt=(state==GNT_CPU), dma_gnt=(state==GNT_DMA).
- IDLE:
  - Only cpu_req → GNT_CPU. Only dma_req → GNT_DMA.
  - Both requesting → grant the master that is not last_owner.
  - Neither → stay in IDLE.
  - Latency: req high at edge n → gnt high after edge n.
- GNT_x:
  - If x's req is sampled low → TURN; last_owner=x.
  - If DMA hold limit is hit (below) → TURN.
  - Otherwise stay.
  - The master must keep req high until its last strobe cycle completes.
- TURN:
  - Exactly one cycle; no owner, strobes all high.
  - Then it applies the IDLE decision rules in the same edge, so a back-to-back handover costs exactly one dead cycle.
- Hold limit:
  - Counter clears on entering GNT_DMA.
  - Increments each GNT_DMA cycle while cpu_req=1.
  - Holds its value while cpu_req=0.
  - When the count reaches DMA_MAX_HOLD → TURN; dma_preempt=1 for that one TURN cycle; last_owner=DMA.
  - The cpu then gets the bus regardless of dma_req.
  - The cpu is never preempted.
- Bus mux (combinational from the registered grant):
  - owner cpu → bus_* = cpu_*. Owner DMA → bus_* = dma_*.
  - No owner → bus_strb_n=11111, bus_data_oe=0, bus_addr and bus_data_out hold their last granted values (registered copy). This guarantees no contention during TURN.
- The non-granted master's inputs never reach the bus.
- Req toggled without a grant: ignored; no state is kept per request.

Test Plan:
- Reset: hold reset 2 cycles with cpu_req=dma_req=1 → all grants 0, bus_strb_n=11111, owner=0. First edge after release → cpu_gnt=1, owner=1.
- Single master: dma_req rises at edge 5, dma_addr=15'h1234, dma_strb_n=5'b01110 → dma_gnt=1 after edge 5, and bus_addr=1234 and bus_strb_n=01110 in the same cycle. dma_req drops → TURN one cycle (strobes 11111), then IDLE.
- Round-robin: both requesting continuously, each releasing after 3 grant cycles → owner sequence 1,1,1,0,2,2,2,0,1,…
- Preempt: DMA_MAX_HOLD=4, DMA owns bus and holds req, cpu_req rises → dma_gnt drops after 4 counted cycles, dma_preempt pulses once, one TURN cycle, then cpu_gnt=1.
- Reset mid-transfer: reset during GNT_DMA with bus_data_oe=1 → after that edge bus_data_oe=0, strobes 11111, last_owner=DMA (cpu wins next tie).
- Isolation: cpu drives cpu_strb_n=00000 and cpu_data_oe=1 while the DMA is granted → bus reflects DMA values only; no cpu values ever appear on the bus.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master (cpu / DMA) bus arbiter: round-robin grant, one-cycle idle turnaround
// between owners, and a hold limit that preempts the DMA when the cpu is waiting.
module bus_arbiter #(
    parameter int unsigned DMA_MAX_HOLD = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    output logic        cpu_gnt,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_data_oe,
    input  logic [4:0]  cpu_strb_n,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [14:0] dma_addr,
    input  logic [15:0] dma_data_out,
    input  logic        dma_data_oe,
    input  logic [4:0]  dma_strb_n,
    output logic        dma_preempt,
    output logic [14:0] bus_addr,
    output logic [15:0] bus_data_out,
    output logic        bus_data_oe,
    output logic [4:0]  bus_strb_n,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2,
        TURN    = 2'd3
    } state_e;

    localparam logic       LAST_CPU   = 1'b0;
    localparam logic       LAST_DMA   = 1'b1;
    localparam logic [7:0] MAX_HOLD_C = 8'(DMA_MAX_HOLD);

    state_e      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        preempt_q, preempt_d;
    logic [14:0] addr_hold_q;
    logic [15:0] data_hold_q;

    // State, arbitration history, hold counter and preempt pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= LAST_DMA;
            hold_cnt_q   <= 8'd0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            preempt_q    <= preempt_d;
        end
    end

    // Next-state logic; IDLE and TURN share the same grant decision.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        preempt_d    = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (cpu_req && (!dma_req || (last_owner_q == LAST_DMA))) begin
                    state_d = GNT_CPU;
                end else if (dma_req) begin
                    state_d    = GNT_DMA;
                    hold_cnt_d = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_CPU: begin
                if (!cpu_req) begin
                    state_d      = TURN;
                    last_owner_d = LAST_CPU;
                end else begin
                    state_d = GNT_CPU;
                end
            end
            GNT_DMA: begin
                // A voluntary release wins over a simultaneous hold-limit hit.
                if (!dma_req) begin
                    state_d      = TURN;
                    last_owner_d = LAST_DMA;
                end else if (cpu_req) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    if ((hold_cnt_q + 8'd1) == MAX_HOLD_C) begin
                        state_d      = TURN;
                        last_owner_d = LAST_DMA;
                        preempt_d    = 1'b1;
                    end else begin
                        state_d = GNT_DMA;
                    end
                end else begin
                    state_d = GNT_DMA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Last granted address/data, replayed on the bus while nobody owns it.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_hold_q <= 15'd0;
            data_hold_q <= 16'd0;
        end else if ((state_q == GNT_CPU) || (state_q == GNT_DMA)) begin
            addr_hold_q <= bus_addr;
            data_hold_q <= bus_data_out;
        end else begin
            addr_hold_q <= addr_hold_q;
            data_hold_q <= data_hold_q;
        end
    end

    // Bus mux and owner decode, driven only by the registered state.
    always_comb begin
        bus_addr     = addr_hold_q;
        bus_data_out = data_hold_q;
        bus_data_oe  = 1'b0;
        bus_strb_n   = 5'b11111;
        owner        = 2'd0;
        case (state_q)
            GNT_CPU: begin
                bus_addr     = cpu_addr;
                bus_data_out = cpu_data_out;
                bus_data_oe  = cpu_data_oe;
                bus_strb_n   = cpu_strb_n;
                owner        = 2'd1;
            end
            GNT_DMA: begin
                bus_addr     = dma_addr;
                bus_data_out = dma_data_out;
                bus_data_oe  = dma_data_oe;
                bus_strb_n   = dma_strb_n;
                owner        = 2'd2;
            end
            default: begin
                owner = 2'd0;
            end
        endcase
    end

    assign cpu_gnt     = (state_q == GNT_CPU);
    assign dma_gnt     = (state_q == GNT_DMA);
    assign dma_preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (DMA hold limit set to 4).
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, dma_req;
    logic        cpu_gnt, dma_gnt, dma_preempt;
    logic [14:0] cpu_addr, dma_addr, bus_addr;
    logic [15:0] cpu_data_out, dma_data_out, bus_data_out;
    logic        cpu_data_oe, dma_data_oe, bus_data_oe;
    logic [4:0]  cpu_strb_n, dma_strb_n, bus_strb_n;
    logic [1:0]  owner;

    int tests_run = 0;
    int tests_failed = 0;

    bus_arbiter #(.DMA_MAX_HOLD(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_addr(cpu_addr),
        .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_strb_n(cpu_strb_n),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_addr(dma_addr),
        .dma_data_out(dma_data_out), .dma_data_oe(dma_data_oe), .dma_strb_n(dma_strb_n),
        .dma_preempt(dma_preempt), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
        .bus_data_oe(bus_data_oe), .bus_strb_n(bus_strb_n), .owner(owner)
    );

    always #5 clock = ~clock;

    // Advance past one rising edge; inputs are then driven and outputs checked at negedge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        cpu_addr = 15'h0abc; cpu_data_out = 16'h5a5a; cpu_data_oe = 1'b0; cpu_strb_n = 5'b10110;
        dma_addr = 15'h0000; dma_data_out = 16'h0000; dma_data_oe = 1'b0; dma_strb_n = 5'b11111;
        tick(); tick();
        @(negedge clock);
        tests_run++;
        if ({cpu_gnt, dma_gnt, dma_preempt, owner, bus_strb_n, bus_data_oe, bus_addr} !==
            {1'b0, 1'b0, 1'b0, 2'd0, 5'b11111, 1'b0, 15'h0000}) begin
            tests_failed++;
            $display("FAIL reset_state: got gnt=%b%b pre=%b own=%0d strb=%b oe=%b addr=%h, want 00 0 0 11111 0 0000",
                     cpu_gnt, dma_gnt, dma_preempt, owner, bus_strb_n, bus_data_oe, bus_addr);
        end
        reset = 1'b0;
        tick();
        @(negedge clock);
        tests_run++;
        if ({cpu_gnt, dma_gnt, owner, bus_addr, bus_strb_n} !== {1'b1, 1'b0, 2'd1, 15'h0abc, 5'b10110}) begin
            tests_failed++;
            $display("FAIL reset_first_tie: got gnt=%b%b own=%0d addr=%h strb=%b, want 10 1 0abc 10110",
                     cpu_gnt, dma_gnt, owner, bus_addr, bus_strb_n);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
        @(negedge clock);
        tests_run++;
        if ({owner, bus_strb_n, bus_data_oe, bus_addr, bus_data_out} !== {2'd0, 5'b11111, 1'b0, 15'h0abc, 16'h5a5a}) begin
            tests_failed++;
            $display("FAIL cpu_turn_hold: got own=%0d strb=%b oe=%b addr=%h data=%h, want 0 11111 0 0abc 5a5a",
                     owner, bus_strb_n, bus_data_oe, bus_addr, bus_data_out);
        end
        tick();
    endtask

    task automatic test_single_master();
        dma_req = 1'b1; dma_addr = 15'h1234; dma_strb_n = 5'b01110;
        dma_data_oe = 1'b1; dma_data_out = 16'hbeef;
        tick();
        @(negedge clock);
        tests_run++;
        if ({cpu_gnt, dma_gnt, owner, bus_addr, bus_strb_n, bus_data_oe, bus_data_out} !==
            {1'b0, 1'b1, 2'd2, 15'h1234, 5'b01110, 1'b1, 16'hbeef}) begin
            tests_failed++;
            $display("FAIL dma_single_grant: got gnt=%b%b own=%0d addr=%h strb=%b oe=%b data=%h, want 01 2 1234 01110 1 beef",
                     cpu_gnt, dma_gnt, owner, bus_addr, bus_strb_n, bus_data_oe, bus_data_out);
        end
        dma_req = 1'b0;
        tick();
        @(negedge clock);
        tests_run++;
        if ({dma_gnt, dma_preempt, owner, bus_strb_n, bus_data_oe, bus_addr, bus_data_out} !==
            {1'b0, 1'b0, 2'd0, 5'b11111, 1'b0, 15'h1234, 16'hbeef}) begin
            tests_failed++;
            $display("FAIL dma_single_turn: got gnt=%b pre=%b own=%0d strb=%b oe=%b addr=%h data=%h, want 0 0 0 11111 0 1234 beef",
                     dma_gnt, dma_preempt, owner, bus_strb_n, bus_data_oe, bus_addr, bus_data_out);
        end
        tick();
        @(negedge clock);
        tests_run++;
        if ({cpu_gnt, dma_gnt, owner} !== {1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL dma_single_idle: got gnt=%b%b own=%0d, want 00 0", cpu_gnt, dma_gnt, owner);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_own [0:12];
        exp_own = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
        dma_data_oe = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            tests_run++;
            if (owner !== exp_own[k]) begin
                tests_failed++;
                $display("FAIL round_robin[%0d]: got owner=%0d, want %0d", k, owner, exp_own[k]);
            end
            cpu_req = !((exp_own[k] == 2'd1) && (exp_own[k+1] == 2'd0));
            dma_req = !((exp_own[k] == 2'd2) && (exp_own[k+1] == 2'd0));
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_preempt();
        dma_req = 1'b1; cpu_req = 1'b0; dma_strb_n = 5'b00000;
        tick(); tick(); tick();
        cpu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clock);
            tests_run++;
            if ({dma_gnt, dma_preempt} !== {1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL preempt_hold[%0d]: got gnt=%b pre=%b, want 1 0", i, dma_gnt, dma_preempt);
            end
        end
        tick();
        @(negedge clock);
        tests_run++;
        if ({dma_gnt, cpu_gnt, dma_preempt, owner, bus_strb_n} !== {1'b0, 1'b0, 1'b1, 2'd0, 5'b11111}) begin
            tests_failed++;
            $display("FAIL preempt_turn: got dgnt=%b cgnt=%b pre=%b own=%0d strb=%b, want 0 0 1 0 11111",
                     dma_gnt, cpu_gnt, dma_preempt, owner, bus_strb_n);
        end
        tick();
        @(negedge clock);
        tests_run++;
        if ({cpu_gnt, dma_gnt, dma_preempt, owner, bus_strb_n} !== {1'b1, 1'b0, 1'b0, 2'd1, 5'b10110}) begin
            tests_failed++;
            $display("FAIL preempt_cpu: got cgnt=%b dgnt=%b pre=%b own=%0d strb=%b, want 1 0 0 1 10110",
                     cpu_gnt, dma_gnt, dma_preempt, owner, bus_strb_n);
        end
        // cpu releases; the still-requesting DMA takes over after one dead cycle.
        cpu_req = 1'b0;
        tick(); tick();
        @(negedge clock);
        tests_run++;
        if (owner !== 2'd2) begin
            tests_failed++;
            $display("FAIL preempt_return: got owner=%0d, want 2", owner);
        end
    endtask

    task automatic test_isolation();
        cpu_strb_n = 5'b00000; cpu_data_oe = 1'b1; cpu_addr = 15'h7fff; cpu_data_out = 16'hffff;
        dma_addr = 15'h0055; dma_data_out = 16'h1111; dma_data_oe = 1'b0; dma_strb_n = 5'b11101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if ({bus_addr, bus_data_out, bus_data_oe, bus_strb_n} !== {15'h0055, 16'h1111, 1'b0, 5'b11101}) begin
                tests_failed++;
                $display("FAIL isolation[%0d]: got addr=%h data=%h oe=%b strb=%b, want 0055 1111 0 11101",
                         i, bus_addr, bus_data_out, bus_data_oe, bus_strb_n);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        dma_data_oe = 1'b1;
        @(negedge clock);
        tests_run++;
        if ({dma_gnt, bus_data_oe} !== {1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL midreset_pre: got gnt=%b oe=%b, want 1 1", dma_gnt, bus_data_oe);
        end
        reset = 1'b1;
        tick();
        @(negedge clock);
        tests_run++;
        if ({dma_gnt, owner, bus_data_oe, bus_strb_n, bus_addr, bus_data_out} !==
            {1'b0, 2'd0, 1'b0, 5'b11111, 15'h0000, 16'h0000}) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got gnt=%b own=%0d oe=%b strb=%b addr=%h data=%h, want 0 0 0 11111 0000 0000",
                     dma_gnt, owner, bus_data_oe, bus_strb_n, bus_addr, bus_data_out);
        end
        reset = 1'b0; cpu_req = 1'b1; dma_req = 1'b1;
        tick();
        @(negedge clock);
        tests_run++;
        if ({cpu_gnt, dma_gnt, owner} !== {1'b1, 1'b0, 2'd1}) begin
            tests_failed++;
            $display("FAIL midreset_tie: got gnt=%b%b own=%0d, want 10 1", cpu_gnt, dma_gnt, owner);
        end
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_round_robin();
        test_preempt();
        test_isolation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
